// File: rtl/fnd_scan_controller_if.sv
// rtl/fnd_scan_controller_if.sv - value/load handshake and FND drive signals of the scan controller
interface fnd_scan_controller_if;
    logic [13:0] i_value;
    logic        i_load;
    logic        o_busy;
    logic        o_ovf;
    logic [1:0]  o_digitSelect;
    logic [7:0]  o_fndFont;

    // Value source side: presents a value and pulses load, watches busy/ovf and the FND drive
    modport master (
        output i_value,
        output i_load,
        input  o_busy,
        input  o_ovf,
        input  o_digitSelect,
        input  o_fndFont
    );

    // Controller side
    modport slave (
        input  i_value,
        input  i_load,
        output o_busy,
        output o_ovf,
        output o_digitSelect,
        output o_fndFont
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - binary-to-BCD double-dabble and 4-digit multiplexed FND scan
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    fnd_scan_controller_if.slave  bus
);
    localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [13:0]     MAX_VALUE  = 14'd9999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t      state_q;
    logic [3:0]  iter_q;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [15:0] disp_q;
    logic        busy_q;
    logic        ovf_q;

    logic [15:0] bcd_adj;
    logic [29:0] dd_shift_d;

    logic [PW-1:0] presc_q;
    logic [1:0]    sel_q;
    logic [1:0]    sel_d;
    logic [7:0]    font_q;
    logic [7:0]    font_d;
    logic [3:0]    digit_d;
    logic [15:0]   upper_d;
    logic          blank_d;

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    seg_font = 8'hC0;
            4'd1:    seg_font = 8'hF9;
            4'd2:    seg_font = 8'hA4;
            4'd3:    seg_font = 8'hB0;
            4'd4:    seg_font = 8'h99;
            4'd5:    seg_font = 8'h92;
            4'd6:    seg_font = 8'h82;
            4'd7:    seg_font = 8'hF8;
            4'd8:    seg_font = 8'h80;
            4'd9:    seg_font = 8'h90;
            default: seg_font = 8'hFF;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the binary MSB in
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_shift_d = {bcd_adj, bin_q} << 1;
    end

    // Controller FSM: capture, 14 conversion iterations, then an atomic commit to the display
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            iter_q  <= 4'd0;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            disp_q  <= 16'd0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_load) begin
                        bin_q   <= (bus.i_value > MAX_VALUE) ? MAX_VALUE : bus.i_value;
                        ovf_q   <= (bus.i_value > MAX_VALUE);
                        bcd_q   <= 16'd0;
                        iter_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q  <= dd_shift_d[29:14];
                    bin_q  <= dd_shift_d[13:0];
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'd13) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    disp_q  <= bcd_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Font is computed for the slot being selected next so select and font change together
    always_comb begin
        sel_d   = (presc_q == PRESC_LAST) ? sel_q + 2'd1 : sel_q;
        digit_d = disp_q[{sel_d, 2'b00} +: 4];
        upper_d = disp_q >> {sel_d, 2'b00};
        blank_d = (BLANK_LZ != 0) && (sel_d != 2'd0) && (upper_d == 16'd0);
        font_d  = blank_d ? 8'hFF : seg_font(digit_d);
    end

    // Free-running slot prescaler and registered select/font outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_q <= '0;
            sel_q   <= 2'd0;
            font_q  <= 8'hFF;
        end else begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            sel_q   <= sel_d;
            font_q  <= font_d;
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_ovf         = ovf_q;
    assign bus.o_digitSelect = sel_q;
    assign bus.o_fndFont     = font_q;
endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Feeds the 4-digit FND display: accepts a binary value 0–9999, converts it to four BCD digits with a sequential double-dabble engine, and time-multiplexes those digits. It drives the 2-bit digit-select code into the downstream 2-to-4 active-low digit decoder, together with the matching active-low 7-segment font for the selected digit. It sits between the value source (counter or application logic) and the digit decoder and FND pins.

## Interface
- SCAN_DIV, 100_000: clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range ≥ 1.
- BLANK_LZ, 1: 1 = blank leading zeros, 0 = show all four digits.

- i_clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_value  input  14  binary value to display
- i_load  input  1  one-cycle request to convert and display i_value
- o_busy  output  1  conversion in progress; i_load ignored while high
- o_ovf  output  1  last accepted i_value was > 9999 and was clamped
- o_digitSelect  output  2  slot index to the digit decoder: 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands
- o_fndFont  output  8  active-low segments {dp,g,f,e,d,c,b,a}

## Operation
- Capture: on i_load=1 with o_busy=0, latch min(i_value, 9999) and set o_ovf = (i_value > 9999). o_busy goes high.
- Conversion: 14-iteration shift-add-3 double-dabble, one iteration per clock, into a 16-bit BCD scratch register. Finishes with a commit cycle.
- Commit: the scratch register is copied atomically into a 16-bit display register. o_busy falls. The display never shows a partial conversion.
- i_load while o_busy=1 is dropped, not queued.
- Controller FSM:
  - IDLE → CONV on an accepted load.
  - CONV stays in CONV for 14 cycles, counted by a 4-bit iteration counter, then → COMMIT.
  - COMMIT → IDLE.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and o_digitSelect increments modulo 4 (3→0).
  - SCAN_DIV=1 advances the slot every cycle.
  - Scan runs continuously and independently of conversion.
- Font, for digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). dp is always off (bit7=1). Any BCD code >9 maps to FF (unreachable, defensive).
- Blanking, when BLANK_LZ=1:
  - Digit n is blanked (FF) if it and every higher digit are 0, for n = 1..3.
  - Digit 0 is never blanked, so value 0 shows "0".
- Reset: aborts any conversion, sets the display register to 0, and returns the FSM to IDLE.

## Timing
- Reset values: o_digitSelect=0, o_fndFont=8'hFF, o_busy=0, o_ovf=0, prescaler=0, display register=0.
- o_digitSelect and o_fndFont are both registered. o_fndFont always corresponds to the slot on o_digitSelect in the same cycle, so there is no ghosting skew between select and font.
- Load latency, with i_load sampled at edge k:
  - o_busy=1 after edge k.
  - Iterations occur at edges k+1..k+14.
  - Commit at edge k+15; o_busy=0 after edge k+15.
  - The new digit appears on o_fndFont after edge k+16 for the currently selected slot.
- Back-to-back loads: the next load is accepted at edge k+16 at the earliest.
- o_ovf updates only at capture, and holds until the next accepted load or reset.
- Slot period: exactly SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.
- Simultaneous i_reset and i_load: reset wins and the load is lost.

## Test plan
- Reset then idle, with SCAN_DIV=4:
  - o_fndFont=FF in the first cycle, then C0 on slot 0.
  - Slots 1–3 show FF.
  - o_digitSelect sequence is 0,1,2,3,0, stepping every 4 cycles.
- Load 1234: o_busy high for exactly 15 cycles. After commit, slots 0..3 show 99, B0, A4, F9.
- Load 10000: o_ovf=1. The display shows 9999, i.e. 90 on every slot.
- Load 7 with BLANK_LZ=1: slot 0 shows F8 and slots 1–3 show FF. Repeat with BLANK_LZ=0: slots 1–3 show C0.
- Load 5678, then pulse i_load with 42 at cycle 5 of the conversion: the second load is ignored, the display shows 5678, and o_busy falls on schedule.
- Assert i_reset at cycle 8 of converting 9999:
  - Next cycle o_busy=0, o_digitSelect=0, o_fndFont=FF.
  - Then "0" on slot 0, and no 9s appear.
